// File: rtl/micro_tiles_pkg.sv
// Shared types and constants for the micro tile selector.
package micro_tiles_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StActive = 2'd2
    } state_e;

    localparam int unsigned DefNTiles    = 8;
    localparam int unsigned DefSettleCyc = 4;
    localparam int unsigned SliceW       = 8;
    localparam int unsigned CntW         = 8;

endpackage

// File: rtl/micro_tile_selector_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous pin followed by a rising-edge pulse.
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/micro_tile_selector.sv
// Selects one of N_TILES micro tiles from three slow pins, enables it after a settle
// delay and muxes its pin slices back out with one cycle of registration.
module micro_tile_selector
    import micro_tiles_pkg::*;
#(
    parameter int unsigned N_TILES    = DefNTiles,
    parameter int unsigned SETTLE_CYC = DefSettleCyc,
    localparam int unsigned SEL_W     = $clog2(N_TILES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic                        sel_clr,
    input  logic                        sel_inc,
    input  logic                        sel_latch,
    input  logic [SliceW*N_TILES-1:0]   tile_uo,
    input  logic [SliceW*N_TILES-1:0]   tile_uio_out,
    input  logic [SliceW*N_TILES-1:0]   tile_uio_oe,
    output logic [N_TILES-1:0]          tile_ena,
    output logic [SliceW-1:0]           uo_out,
    output logic [SliceW-1:0]           uio_out,
    output logic [SliceW-1:0]           uio_oe,
    output logic [SEL_W-1:0]            sel_addr,
    output logic                        active
);

    state_e             r_state;
    logic [SEL_W-1:0]   r_addr;
    logic [CntW-1:0]    r_cnt;
    logic [SliceW-1:0]  r_uo;
    logic [SliceW-1:0]  r_uio_out;
    logic [SliceW-1:0]  r_uio_oe;

    logic               w_clr;
    logic               w_inc;
    logic               w_latch;
    logic [N_TILES-1:0] w_onehot;
    logic [SliceW-1:0]  w_uo;
    logic [SliceW-1:0]  w_uio_out;
    logic [SliceW-1:0]  w_uio_oe;

    sync_edge_det u_sync_clr (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_pin  (sel_clr),
        .o_rise (w_clr)
    );

    sync_edge_det u_sync_inc (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_pin  (sel_inc),
        .o_rise (w_inc)
    );

    sync_edge_det u_sync_latch (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_pin  (sel_latch),
        .o_rise (w_latch)
    );

    always_comb begin
        w_onehot  = '0;
        w_uo      = '0;
        w_uio_out = '0;
        w_uio_oe  = '0;
        for (int i = 0; i < int'(N_TILES); i++) begin
            if (r_addr == SEL_W'(i)) begin
                w_onehot[i] = 1'b1;
                w_uo        = tile_uo[i*SliceW +: SliceW];
                w_uio_out   = tile_uio_out[i*SliceW +: SliceW];
                w_uio_oe    = tile_uio_oe[i*SliceW +: SliceW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_uo      <= '0;
            r_uio_out <= '0;
            r_uio_oe  <= '0;
        end else begin
            // Output slices follow the state as it was before this edge.
            r_uo      <= (r_state == StActive) ? w_uo      : '0;
            r_uio_out <= (r_state == StActive) ? w_uio_out : '0;
            r_uio_oe  <= (r_state == StActive) ? w_uio_oe  : '0;

            if (!ena) begin
                r_state <= StIdle;
                r_cnt   <= '0;
            end else if (w_clr) begin
                r_addr  <= '0;
                r_state <= StIdle;
                r_cnt   <= '0;
            end else if (w_inc) begin
                r_addr  <= (r_addr == SEL_W'(N_TILES - 1)) ? '0 : r_addr + SEL_W'(1);
                r_state <= StIdle;
                r_cnt   <= '0;
            end else if (w_latch) begin
                r_cnt   <= CntW'(SETTLE_CYC);
                r_state <= StSettle;
            end else begin
                case (r_state)
                    StSettle: begin
                        if (r_cnt <= CntW'(1)) begin
                            r_cnt   <= '0;
                            r_state <= StActive;
                        end else begin
                            r_cnt <= r_cnt - CntW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tile_ena = (r_state == StActive) ? w_onehot : '0;
    assign active   = (r_state == StActive);
    assign sel_addr = r_addr;
    assign uo_out   = r_uo;
    assign uio_out  = r_uio_out;
    assign uio_oe   = r_uio_oe;

endmodule

// File: tb/tb_micro_tile_selector.sv
// Directed bench for micro_tile_selector with default parameters (8 tiles, settle 4).
module tb_micro_tile_selector;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        sel_clr;
    logic        sel_inc;
    logic        sel_latch;
    logic [63:0] tile_uo;
    logic [63:0] tile_uio_out;
    logic [63:0] tile_uio_oe;
    logic [7:0]  tile_ena;
    logic [7:0]  uo_out;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;
    logic [2:0]  sel_addr;
    logic        active;

    int n_chk;
    int n_fail;

    micro_tile_selector #(
        .N_TILES    (8),
        .SETTLE_CYC (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .sel_clr      (sel_clr),
        .sel_inc      (sel_inc),
        .sel_latch    (sel_latch),
        .tile_uo      (tile_uo),
        .tile_uio_out (tile_uio_out),
        .tile_uio_oe  (tile_uio_oe),
        .tile_ena     (tile_ena),
        .uo_out       (uo_out),
        .uio_out      (uio_out),
        .uio_oe       (uio_oe),
        .sel_addr     (sel_addr),
        .active       (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pin high for one sampled edge, then low; the event lands one tick after return.
    task automatic pulse_inc();
        sel_inc = 1'b1;
        tick();
        sel_inc = 1'b0;
        tick();
    endtask

    task automatic pulse_latch();
        sel_latch = 1'b1;
        tick();
        sel_latch = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ena = 1'b1;
        sel_clr = 1'b0;
        sel_inc = 1'b0;
        sel_latch = 1'b0;
        tile_uo = '0;
        tile_uio_out = '0;
        tile_uio_oe = '0;
        tick();
        tick();
        n_chk++;
        if (sel_addr !== 3'd0) begin
            $display("FAIL reset_addr: got %0d expected 0", sel_addr);
            n_fail++;
        end
        n_chk++;
        if (tile_ena !== 8'h00 || active !== 1'b0) begin
            $display("FAIL reset_ena: got tile_ena=%h active=%b expected 00/0", tile_ena, active);
            n_fail++;
        end
        n_chk++;
        if ({uo_out, uio_out, uio_oe} !== 24'h0) begin
            $display("FAIL reset_outputs: got %h/%h/%h expected 0", uo_out, uio_out, uio_oe);
            n_fail++;
        end
        rst = 1'b0;
        tick();
        n_chk++;
        if (tile_ena !== 8'h00 || sel_addr !== 3'd0) begin
            $display("FAIL post_reset: got tile_ena=%h addr=%0d expected 00/0", tile_ena, sel_addr);
            n_fail++;
        end
    endtask

    task automatic test_select_and_settle();
        tile_uo[3*8 +: 8]      = 8'hA5;
        tile_uo[2*8 +: 8]      = 8'h3C;
        tile_uio_out[3*8 +: 8] = 8'h0F;
        tile_uio_oe[3*8 +: 8]  = 8'hF0;
        for (int i = 0; i < 3; i++) pulse_inc();
        tick();
        n_chk++;
        if (sel_addr !== 3'd3) begin
            $display("FAIL inc3_addr: got %0d expected 3", sel_addr);
            n_fail++;
        end
        pulse_latch();
        tick();
        n_chk++;
        if (tile_ena !== 8'h00 || active !== 1'b0) begin
            $display("FAIL settle_enter: got tile_ena=%h active=%b expected 00/0", tile_ena, active);
            n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (tile_ena !== 8'h00) begin
                $display("FAIL settle_early_%0d: got tile_ena=%h expected 00", i, tile_ena);
                n_fail++;
            end
        end
        tick();
        n_chk++;
        if (tile_ena !== 8'h08 || active !== 1'b1) begin
            $display("FAIL settle_done: got tile_ena=%h active=%b expected 08/1", tile_ena, active);
            n_fail++;
        end
        n_chk++;
        if (uo_out !== 8'h00) begin
            $display("FAIL uo_latency: got %h expected 00 on first ACTIVE cycle", uo_out);
            n_fail++;
        end
    endtask

    task automatic test_output_mux();
        tick();
        n_chk++;
        if (uo_out !== 8'hA5 || uio_out !== 8'h0F || uio_oe !== 8'hF0) begin
            $display("FAIL mux_tile3: got %h/%h/%h expected a5/0f/f0", uo_out, uio_out, uio_oe);
            n_fail++;
        end
        tile_uo[2*8 +: 8] = 8'hFF;
        tick();
        n_chk++;
        if (uo_out !== 8'hA5) begin
            $display("FAIL mux_other_slice: got %h expected a5", uo_out);
            n_fail++;
        end
        tile_uo[3*8 +: 8] = 8'h5A;
        tick();
        n_chk++;
        if (uo_out !== 8'h5A) begin
            $display("FAIL mux_follow: got %h expected 5a", uo_out);
            n_fail++;
        end
    endtask

    task automatic test_wrap();
        tile_uo[7*8 +: 8]     = 8'h77;
        tile_uio_oe[7*8 +: 8] = 8'hC3;
        pulse_inc();
        n_chk++;
        if (active !== 1'b1) begin
            $display("FAIL inc_sync_delay: got active=%b expected 1", active);
            n_fail++;
        end
        tick();
        n_chk++;
        if (sel_addr !== 3'd4 || tile_ena !== 8'h00 || active !== 1'b0) begin
            $display("FAIL inc_leave: got addr=%0d ena=%h act=%b expected 4/00/0",
                     sel_addr, tile_ena, active);
            n_fail++;
        end
        tick();
        n_chk++;
        if ({uo_out, uio_out, uio_oe} !== 24'h0) begin
            $display("FAIL inc_outputs: got %h/%h/%h expected 0", uo_out, uio_out, uio_oe);
            n_fail++;
        end
        for (int i = 0; i < 3; i++) pulse_inc();
        tick();
        pulse_latch();
        for (int i = 0; i < 5; i++) tick();
        n_chk++;
        if (tile_ena !== 8'h80 || sel_addr !== 3'd7) begin
            $display("FAIL tile7: got ena=%h addr=%0d expected 80/7", tile_ena, sel_addr);
            n_fail++;
        end
        pulse_inc();
        n_chk++;
        if (uo_out !== 8'h77 || uio_oe !== 8'hC3) begin
            $display("FAIL mux_tile7: got %h/%h expected 77/c3", uo_out, uio_oe);
            n_fail++;
        end
        tick();
        n_chk++;
        if (sel_addr !== 3'd0 || tile_ena !== 8'h00 || active !== 1'b0) begin
            $display("FAIL wrap: got addr=%0d ena=%h act=%b expected 0/00/0",
                     sel_addr, tile_ena, active);
            n_fail++;
        end
        tick();
        n_chk++;
        if ({uo_out, uio_out, uio_oe} !== 24'h0) begin
            $display("FAIL wrap_outputs: got %h/%h/%h expected 0", uo_out, uio_out, uio_oe);
            n_fail++;
        end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 5; i++) pulse_inc();
        tick();
        n_chk++;
        if (sel_addr !== 3'd5) begin
            $display("FAIL addr5: got %0d expected 5", sel_addr);
            n_fail++;
        end
        sel_clr = 1'b1;
        sel_inc = 1'b1;
        tick();
        sel_clr = 1'b0;
        sel_inc = 1'b0;
        tick();
        tick();
        n_chk++;
        if (sel_addr !== 3'd0) begin
            $display("FAIL clr_over_inc: got %0d expected 0", sel_addr);
            n_fail++;
        end
        sel_inc = 1'b1;
        sel_latch = 1'b1;
        tick();
        sel_inc = 1'b0;
        sel_latch = 1'b0;
        tick();
        tick();
        n_chk++;
        if (sel_addr !== 3'd1 || active !== 1'b0) begin
            $display("FAIL inc_over_latch: got addr=%0d act=%b expected 1/0", sel_addr, active);
            n_fail++;
        end
        for (int i = 0; i < 6; i++) tick();
        n_chk++;
        if (tile_ena !== 8'h00) begin
            $display("FAIL latch_discarded: got ena=%h expected 00", tile_ena);
            n_fail++;
        end
    endtask

    task automatic test_ena_gate();
        tile_uo[1*8 +: 8] = 8'h11;
        pulse_latch();
        for (int i = 0; i < 5; i++) tick();
        n_chk++;
        if (tile_ena !== 8'h02) begin
            $display("FAIL tile1: got ena=%h expected 02", tile_ena);
            n_fail++;
        end
        ena = 1'b0;
        tick();
        n_chk++;
        if (tile_ena !== 8'h00 || active !== 1'b0) begin
            $display("FAIL ena_drop: got ena=%h act=%b expected 00/0", tile_ena, active);
            n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            pulse_inc();
            n_chk++;
            if (sel_addr !== 3'd1 || tile_ena !== 8'h00) begin
                $display("FAIL ena_low_%0d: got addr=%0d ena=%h expected 1/00", i, sel_addr, tile_ena);
                n_fail++;
            end
        end
        tick();
        n_chk++;
        if (sel_addr !== 3'd1 || uo_out !== 8'h00) begin
            $display("FAIL ena_low_end: got addr=%0d uo=%h expected 1/00", sel_addr, uo_out);
            n_fail++;
        end
        ena = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        n_chk++;
        if (sel_addr !== 3'd1 || tile_ena !== 8'h00) begin
            $display("FAIL ena_rise: got addr=%0d ena=%h expected 1/00", sel_addr, tile_ena);
            n_fail++;
        end
        pulse_latch();
        for (int i = 0; i < 5; i++) tick();
        n_chk++;
        if (tile_ena !== 8'h02) begin
            $display("FAIL ena_relatch: got ena=%h expected 02", tile_ena);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_settle();
        pulse_latch();
        tick();
        n_chk++;
        if (tile_ena !== 8'h00) begin
            $display("FAIL relatch_restart: got ena=%h expected 00", tile_ena);
            n_fail++;
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_chk++;
        if (tile_ena !== 8'h00 || active !== 1'b0 || sel_addr !== 3'd0 ||
            {uo_out, uio_out, uio_oe} !== 24'h0) begin
            $display("FAIL rst_settle: got ena=%h act=%b addr=%0d outs=%h/%h/%h expected all 0",
                     tile_ena, active, sel_addr, uo_out, uio_out, uio_oe);
            n_fail++;
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_chk++;
            if (tile_ena !== 8'h00) begin
                $display("FAIL rst_settle_after_%0d: got ena=%h expected 00", i, tile_ena);
                n_fail++;
            end
        end
    endtask

    task automatic test_held_through_reset();
        rst = 1'b1;
        sel_inc = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_chk++;
        if (sel_addr !== 3'd1) begin
            $display("FAIL held_pin: got addr=%0d expected 1", sel_addr);
            n_fail++;
        end
        sel_inc = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_chk++;
        if (sel_addr !== 3'd1) begin
            $display("FAIL held_pin_release: got addr=%0d expected 1", sel_addr);
            n_fail++;
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        test_reset();
        test_select_and_settle();
        test_output_mux();
        test_wrap();
        test_priority();
        test_ena_gate();
        test_reset_mid_settle();
        test_held_through_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/micro_tile_selector.md
MICRO_TILE_SELECTOR -- requirements
Module: micro_tile_selector

Interface
REQ-001 SHALL have parameter N_TILES, default 8: number of micro tiles behind the container; legal range 2..16.
REQ-002 SHALL have parameter SETTLE_CYC, default 4: cycles between latch and tile enable; legal range 1..255.
REQ-003 SHALL derive localparam SEL_W = clog2(N_TILES).
REQ-004 Ports SHALL be:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- ena  in  1  container enabled, high while the design is selected.
- sel_clr  in  1  asynchronous pin level; rising edge clears the tile address.
- sel_inc  in  1  asynchronous pin level; rising edge increments the tile address.
- sel_latch  in  1  asynchronous pin level; rising edge commits the address.
- tile_uo  in  8*N_TILES  uo_out of every tile, tile i at bits [8i+7:8i].
- tile_uio_out  in  8*N_TILES  uio_out of every tile, same packing.
- tile_uio_oe  in  8*N_TILES  uio_oe of every tile, same packing.
- tile_ena  out  N_TILES  one-hot enable to the tiles.
- uo_out  out  8  muxed dedicated outputs.
- uio_out  out  8  muxed bidir outputs.
- uio_oe  out  8  muxed bidir enables; 1 = output.
- sel_addr  out  SEL_W  current address counter.
- active  out  1  high while a tile is enabled.

Function
REQ-005 SHALL pass each sel_* pin through a 2-flop synchronizer and a rising-edge detector; a pin first sampled high at edge k SHALL take effect at edge k+2.
REQ-006 The FSM SHALL have states IDLE, SETTLE, ACTIVE.
REQ-007 sel_clr event SHALL set sel_addr=0 and force IDLE from any state.
REQ-008 sel_inc event SHALL set sel_addr = sel_addr+1 and wrap from N_TILES-1 to 0; it SHALL force IDLE from any state.
REQ-009 sel_latch event in IDLE SHALL load the settle counter with SETTLE_CYC and enter SETTLE.
REQ-010 sel_latch event in SETTLE or ACTIVE SHALL restart SETTLE with the current address.
REQ-011 For simultaneous events, priority SHALL be clr > inc > latch; lower-priority events in the same cycle are discarded.
REQ-012 SETTLE SHALL decrement the counter each cycle and enter ACTIVE on the edge where the counter reaches 0, exactly SETTLE_CYC edges after entering SETTLE.
REQ-013 In ACTIVE, tile_ena SHALL be one-hot at bit sel_addr; in every other state it SHALL be 0.
REQ-014 active SHALL be high exactly when the state is ACTIVE.
REQ-015 uo_out, uio_out and uio_oe SHALL be registered with 1-cycle latency from the selected tile slice while ACTIVE, and SHALL be 0 in the cycle after leaving ACTIVE.
REQ-016 ena low SHALL force IDLE and ignore all sel events; sel_addr SHALL be retained, and the synchronizers SHALL keep running so no stale edge fires when ena rises.

Reset
REQ-017 rst SHALL set state=IDLE, sel_addr=0, settle counter=0, all synchronizer and edge flops=0, tile_ena=0, and uo_out/uio_out/uio_oe=0.
REQ-018 rst asserted mid-SETTLE or mid-ACTIVE SHALL drop tile_ena on the same edge.
REQ-019 A pin held high through reset release SHALL produce one event after release.

Structure
REQ-020 Package micro_tiles_pkg SHALL hold the state enum, the default N_TILES and SETTLE_CYC, and the pin-slice width constant 8.
REQ-021 Sub-module sync_edge_det (2-flop sync plus rising-edge pulse) SHALL be instantiated three times; the FSM and the output mux SHALL stay in micro_tile_selector.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Reset, then 3 sel_inc pulses, then sel_latch -> sel_addr=3; tile_ena=8'h08 exactly 4 cycles after the latch event; active=1.
- ACTIVE on tile 3 with tile_uo slice=8'hA5 -> uo_out=8'hA5 one cycle later; slice 2 changes have no effect.
- sel_addr=7, one sel_inc -> sel_addr=0; state IDLE; tile_ena=0; outputs 0 next cycle.
- sel_clr and sel_inc rise in the same cycle with sel_addr=5 -> sel_addr=0.
- ACTIVE, drop ena for 10 cycles while pulsing sel_inc -> tile_ena=0 and sel_addr unchanged; after ena rises, no enable until a new latch.
- rst asserted 2 cycles into SETTLE -> no tile_ena pulse; all outputs 0.
